// File: rtl/user_proj_counter_array.sv
// Bank of NUM_CH Wishbone-programmable counters with LA pause, IO toggles and a shared irq.
// Latency: registered Wishbone ack and read data one cycle after the request; done/io_out on the match edge, irq one cycle later.
// Backpressure: the slave never stalls; at most one ack every two cycles, and the master holds stb until ack.
//
// Ports: wb_clk_i/wb_rst_i (async active-high), wbs_* Wishbone classic slave,
//        la_data_in/la_oenb (per-channel pause on bit 32+ch), la_data_out (channel 0 COUNT),
//        io_in (unused), io_out (per-channel terminal-count toggle), io_oeb, irq[0] (done & ie).
// Optional feature macro: USER_PROJ_CNT_PRESCALE_EN adds a global 8-bit PRESCALE register at 0xF0.
module user_proj_counter_array #(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    input  logic [127:0] la_data_in,
    input  logic [127:0] la_oenb,
    output logic [127:0] la_data_out,
    input  logic [37:0]  io_in,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb,
    output logic [2:0]   irq
);

    localparam logic [37:0] OEB_VAL = ~((38'd1 << NUM_CH) - 38'd1);

    logic       req;
    logic       wr;
    logic [3:0] ch_sel;
    logic [1:0] reg_sel;
    logic       tick;
    logic       unused_inputs;

    // Slot 15 is never a channel, so 16-entry views let ch_sel index directly;
    // entries at or above NUM_CH are tied to zero and therefore read back 0.
    logic [15:0]            en_vec;
    logic [15:0]            os_vec;
    logic [15:0]            ie_vec;
    logic [15:0]            done_vec;
    logic [15:0][CNT_W-1:0] cnt_vec;
    logic [15:0][CNT_W-1:0] lim_vec;
    logic [NUM_CH-1:0]      tog_vec;
    logic [NUM_CH-1:0]      pause;
    logic [31:0]            rdata;

    assign req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
    assign wr      = req & wbs_we_i;
    assign ch_sel  = wbs_adr_i[7:4];
    assign reg_sel = wbs_adr_i[3:2];
    assign pause   = ~la_oenb[32 +: NUM_CH] & la_data_in[32 +: NUM_CH];

    assign unused_inputs = &{1'b0, io_in, la_data_in, la_oenb};

    // Byte-lane merge of write data into an existing CNT_W-bit register.
    function automatic logic [CNT_W-1:0] merge_bytes(input logic [CNT_W-1:0] old_val);
        logic [31:0] w;
        w = 32'(old_val);
        for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) w[8*b +: 8] = wbs_dat_i[8*b +: 8];
        end
        return w[CNT_W-1:0];
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_ch
        if (i < NUM_CH) begin : g_live
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] lim_q;
            logic             en_q, os_q, ie_q, done_q, tog_q;
            logic             wr_ch, adv, match;

            assign wr_ch = wr & (ch_sel == 4'(i));
            assign adv   = en_q & ~pause[i] & tick;
            assign match = (cnt_q == lim_q);

            // Later assignments win: Wishbone writes to COUNT/CTRL override the
            // counter update, and a match-set of done overrides a same-cycle W1C.
            always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
                if (wb_rst_i) begin
                    cnt_q  <= '0;
                    lim_q  <= '1;
                    en_q   <= 1'b0;
                    os_q   <= 1'b0;
                    ie_q   <= 1'b0;
                    done_q <= 1'b0;
                    tog_q  <= 1'b0;
                end else begin
                    if (wr_ch && reg_sel == 2'd3 && wbs_sel_i[0] && wbs_dat_i[0]) done_q <= 1'b0;
                    if (adv) begin
                        if (match) begin
                            done_q <= 1'b1;
                            tog_q  <= ~tog_q;
                            if (os_q) en_q  <= 1'b0;
                            else      cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    if (wr_ch && reg_sel == 2'd0 && wbs_sel_i[0]) begin
                        en_q <= wbs_dat_i[0];
                        os_q <= wbs_dat_i[1];
                        ie_q <= wbs_dat_i[2];
                    end
                    if (wr_ch && reg_sel == 2'd1) cnt_q <= merge_bytes(cnt_q);
                    if (wr_ch && reg_sel == 2'd2) lim_q <= merge_bytes(lim_q);
                end
            end

            assign en_vec[i]   = en_q;
            assign os_vec[i]   = os_q;
            assign ie_vec[i]   = ie_q;
            assign done_vec[i] = done_q;
            assign cnt_vec[i]  = cnt_q;
            assign lim_vec[i]  = lim_q;
            assign tog_vec[i]  = tog_q;
        end else begin : g_pad
            assign en_vec[i]   = 1'b0;
            assign os_vec[i]   = 1'b0;
            assign ie_vec[i]   = 1'b0;
            assign done_vec[i] = 1'b0;
            assign cnt_vec[i]  = '0;
            assign lim_vec[i]  = '0;
        end
    end

`ifdef USER_PROJ_CNT_PRESCALE_EN
    logic [7:0] prescale_q;
    logic [7:0] div_q;

    assign tick = (div_q == prescale_q);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            prescale_q <= 8'd0;
            div_q      <= 8'd0;
        end else if (wr && wbs_adr_i[7:0] == 8'hF0 && wbs_sel_i[0]) begin
            prescale_q <= wbs_dat_i[7:0];
            div_q      <= 8'd0;
        end else begin
            div_q <= tick ? 8'd0 : div_q + 8'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        rdata = '0;
        if (wbs_adr_i[7:0] == 8'hF0) begin
`ifdef USER_PROJ_CNT_PRESCALE_EN
            rdata = {24'd0, prescale_q};
`endif
        end else begin
            case (reg_sel)
                2'd0:    rdata = {29'd0, ie_vec[ch_sel], os_vec[ch_sel], en_vec[ch_sel]};
                2'd1:    rdata = 32'(cnt_vec[ch_sel]);
                2'd2:    rdata = 32'(lim_vec[ch_sel]);
                default: rdata = {31'd0, done_vec[ch_sel]};
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            irq       <= 3'd0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req & ~wbs_we_i) ? rdata : 32'd0;
            irq       <= {2'b00, |(done_vec & ie_vec)};
        end
    end

    assign la_data_out = 128'(cnt_vec[0]);
    assign io_out      = 38'(tog_vec);
    assign io_oeb      = OEB_VAL;

endmodule

// File: tb/tb_user_proj_counter_array.sv
module tb_user_proj_counter_array;

    localparam int          NUM_CH = 4;
    localparam int          CNT_W  = 16;
    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] MASK   = (CNT_W == 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]   sel = 4'h0;
    logic [31:0]  adr = 32'd0, dat_i = 32'd0;
    logic         ack;
    logic [31:0]  dat_o;
    logic [127:0] la_in = '0, la_oenb = '1, la_out;
    logic [37:0]  io_in = '0, io_out, io_oeb;
    logic [2:0]   irq;

    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b0;

    user_proj_counter_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BASE_ADDR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .la_data_in(la_in), .la_oenb(la_oenb), .la_data_out(la_out),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_cnt [NUM_CH];
    logic [31:0] m_lim [NUM_CH];
    bit          m_en [NUM_CH], m_os [NUM_CH], m_ie [NUM_CH], m_done [NUM_CH], m_tog [NUM_CH];
    bit          m_ack, m_irq;
    logic [31:0] m_dat;
    int          m_pre, m_since;

    function automatic logic [31:0] a_of(input int ch, input int r);
        return BASE | 32'(ch << 4) | 32'(r << 2);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int c = int'(a[7:4]);
        if (a[7:0] == 8'hF0) begin
`ifdef USER_PROJ_CNT_PRESCALE_EN
            return 32'(m_pre);
`else
            return 32'd0;
`endif
        end
        if (c >= NUM_CH) return 32'd0;
        case (a[3:2])
            2'd0:    return {29'd0, m_ie[c], m_os[c], m_en[c]};
            2'd1:    return m_cnt[c];
            2'd2:    return m_lim[c];
            default: return {31'd0, m_done[c]};
        endcase
    endfunction

    function automatic logic [31:0] apply_bytes(input logic [31:0] old_v, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v = old_v;
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        return v & MASK;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_lim[c] = MASK; m_en[c] = 0; m_os[c] = 0;
            m_ie[c] = 0; m_done[c] = 0; m_tog[c] = 0;
        end
        m_ack = 0; m_irq = 0; m_dat = 0; m_pre = 0; m_since = 0;
    endtask

    task automatic model_step();
        bit req, tick, restart;
        bit setd [NUM_CH];
        logic [31:0] nd;
        bit nirq;
        int c;
        req = cyc && stb && (adr[31:8] == BASE[31:8]) && !m_ack;
        nd  = (req && !we) ? model_read(adr) : 32'd0;
        nirq = 0;
        for (int k = 0; k < NUM_CH; k++) if (m_done[k] && m_ie[k]) nirq = 1;
`ifdef USER_PROJ_CNT_PRESCALE_EN
        tick = ((m_since % (m_pre + 1)) == m_pre);
`else
        tick = 1;
`endif
        restart = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            setd[k] = 0;
            if (m_en[k] && !(la_oenb[32+k] == 1'b0 && la_in[32+k] == 1'b1) && tick) begin
                if (m_cnt[k] == m_lim[k]) begin
                    m_done[k] = 1; setd[k] = 1; m_tog[k] = !m_tog[k];
                    if (m_os[k]) m_en[k] = 0; else m_cnt[k] = 0;
                end else begin
                    m_cnt[k] = (m_cnt[k] + 1) & MASK;
                end
            end
        end
        if (req && we) begin
            c = int'(adr[7:4]);
            if (adr[7:0] == 8'hF0) begin
`ifdef USER_PROJ_CNT_PRESCALE_EN
                if (sel[0]) begin m_pre = int'(dat_i[7:0]); restart = 1; end
`endif
            end else if (c < NUM_CH) begin
                case (adr[3:2])
                    2'd0: if (sel[0]) begin m_en[c] = dat_i[0]; m_os[c] = dat_i[1]; m_ie[c] = dat_i[2]; end
                    2'd1: m_cnt[c] = apply_bytes(m_cnt[c], dat_i, sel);
                    2'd2: m_lim[c] = apply_bytes(m_lim[c], dat_i, sel);
                    default: if (sel[0] && dat_i[0] && !setd[c]) m_done[c] = 0;
                endcase
            end
        end
        m_since = restart ? 0 : m_since + 1;
        m_ack = req;
        m_dat = nd;
        m_irq = nirq;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Cycle-by-cycle comparison of every observable output against the model.
    always @(posedge clk) begin
        logic [37:0] eio;
        #1;
        if (mon_on) begin
            eio = '0;
            for (int k = 0; k < NUM_CH; k++) eio[k] = m_tog[k];
            check("ack", ack, m_ack);
            check("dat_o", dat_o, m_dat);
            check("irq", irq, {2'b00, m_irq});
            check("io_out", io_out, eio);
            check("la_out", la_out, 128'(m_cnt[0] & MASK));
            check("io_oeb", io_oeb, 38'h3F_FFFF_FFF0);
        end
    end

    // ---------------- bus stimulus ----------------
    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rd, output bit acked);
        @(negedge clk);
        adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
        acked = 0; rd = 32'd0;
        for (int k = 0; k < 4 && !acked; k++) begin
            @(posedge clk); #1;
            if (ack) begin acked = 1; rd = dat_o; end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd; bit acked;
        wb_xfer(a, 1'b1, d, 4'hF, rd, acked);
        check("wr_ack", acked, 1'b1);
    endtask

    task automatic wb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd; bit acked;
        wb_xfer(a, 1'b0, 32'd0, 4'hF, rd, acked);
        check({tag, "_ack"}, acked, 1'b1);
        check(tag, rd, exp);
    endtask

    task automatic read_reset_values();
        logic [31:0] expv [4];
        expv[0] = 32'd0; expv[1] = 32'd0; expv[2] = 32'h0000_FFFF; expv[3] = 32'd0;
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < 4; r++)
                wb_read($sformatf("rst_ch%0d_r%0d", c, r), a_of(c, r), expv[r]);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got, base;
        logic [31:0] rd, a, d;
        logic [3:0]  s;
        bit          acked;
        int          op;

        model_reset();
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        mon_on = 1'b1;

        // Reset state
        check("rst_irq", irq, 3'd0);
        check("rst_io_oeb", io_oeb, 38'h3F_FFFF_FFF0);
        read_reset_values();

        // ch1 wrap mode with interrupt
        wb_write(a_of(1, 2), 32'd3);
        wb_write(a_of(1, 0), 32'h5);
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin @(posedge clk); #1; got = irq[0]; end
        check("ch1_irq_rise", got, 1'b1);
        check("ch1_io_toggle", io_out[1], 1'b1);
        wb_write(a_of(1, 0), 32'h4);
        wb_write(a_of(1, 3), 32'h1);
        repeat (2) @(posedge clk);
        #1 check("ch1_irq_clear", irq, 3'd0);

        // ch2 one-shot
        wb_write(a_of(2, 2), 32'd5);
        wb_write(a_of(2, 0), 32'h3);
        repeat (12) @(posedge clk);
        wb_read("ch2_count", a_of(2, 1), 32'd5);
        wb_read("ch2_ctrl", a_of(2, 0), 32'h2);
        wb_read("ch2_done", a_of(2, 3), 32'h1);
        wb_write(a_of(2, 1), 32'h1234);
        repeat (3) @(posedge clk);
        wb_read("ch2_count_hold", a_of(2, 1), 32'h1234);

        // ch0 LA pause
        @(negedge clk); la_oenb[32] = 1'b0; la_in[32] = 1'b1;
        wb_write(a_of(0, 1), 32'h40);
        wb_write(a_of(0, 0), 32'h1);
        repeat (10) @(posedge clk);
        #1 check("ch0_paused", la_out[15:0], 16'h0040);
        wb_read("ch7_read", a_of(7, 1), 32'd0);
        @(negedge clk); la_oenb[32] = 1'b1; la_in[32] = 1'b0;
        repeat (5) @(posedge clk);

        // Wishbone COUNT write beats a same-cycle advance
        wb_write(a_of(0, 1), 32'h0100);
        check("cnt_wr_wins", la_out[15:0], 16'h0100);
        @(posedge clk); #1 check("cnt_after_wr", la_out[15:0], 16'h0101);

        // done set beats a same-cycle W1C (LIMIT=0 matches every cycle)
        wb_write(a_of(3, 2), 32'd0);
        wb_write(a_of(3, 0), 32'h1);
        wb_write(a_of(3, 3), 32'h1);
        wb_read("ch3_done_kept", a_of(3, 3), 32'h1);
        wb_write(a_of(3, 0), 32'h0);
        wb_write(a_of(0, 0), 32'h0);

`ifdef USER_PROJ_CNT_PRESCALE_EN
        @(negedge clk); la_oenb[33] = 1'b0; la_in[33] = 1'b1;
        wb_write(a_of(1, 2), 32'd2);
        wb_write(a_of(1, 1), 32'd0);
        wb_write(a_of(1, 0), 32'h1);
        wb_write(BASE | 32'hF0, 32'd3);
        la_oenb[33] = 1'b1; la_in[33] = 1'b0;
        base = m_tog[1];
        repeat (11) @(posedge clk);
        #1 check("pre_not_yet", io_out[1], base);
        @(posedge clk); #1 check("pre_toggle_12", io_out[1], !base);
        wb_read("pre_readback", BASE | 32'hF0, 32'd3);
        wb_write(BASE | 32'hF0, 32'd0);
        wb_write(a_of(1, 0), 32'h0);
`else
        wb_write(BASE | 32'hF0, 32'd3);
        wb_read("pre_absent", BASE | 32'hF0, 32'd0);
`endif

        // Randomized traffic, checked every cycle by the model comparison
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                la_oenb[35:32] = 4'($urandom);
                la_in[35:32]   = 4'($urandom);
            end
            op = $urandom_range(0, 9);
            a  = a_of($urandom_range(0, 5), $urandom_range(0, 3));
            if ($urandom_range(0, 12) == 0) a = BASE | 32'hF0;
            if ($urandom_range(0, 9) == 0)  a = a ^ 32'h0000_0100;
            d = ($urandom_range(0, 4) == 0) ? 32'($urandom) : 32'($urandom_range(0, 12));
            if (a[3:2] == 2'd0 && a[7:0] != 8'hF0) d = 32'($urandom_range(0, 7)) | 32'h1;
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if (op < 4)      wb_xfer(a, 1'b1, d, s, rd, acked);
            else if (op < 7) wb_xfer(a, 1'b0, 32'd0, 4'hF, rd, acked);
            else             repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        la_oenb = '1; la_in = '0;

        // Reset asserted while a read is being acknowledged
        @(negedge clk);
        adr = a_of(1, 2); we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("rst_mid_ack", ack, 1'b0);
        check("rst_mid_dat", dat_o, 32'd0);
        check("rst_mid_irq", irq, 3'd0);
        check("rst_mid_io", io_out, 38'd0);
        @(negedge clk); cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        read_reset_values();
        check("post_rst_la", la_out, 128'd0);

        repeat (2) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
